// File: rtl/memory_access.sv
// Memory-access pipeline stage: registers the execute-stage result, runs a
// request/ack data-memory handshake and lane-aligns stores and loads.
// Optional build macro: MEM_MISALIGN_CHECK_EN traps misaligned half/word accesses.
`timescale 1ns/1ps

module memory_access #(
    parameter int DATA_SIZE = 32,
    parameter int INST_SIZE = 32,
    parameter int NUM_REGS  = 32,
    localparam int RW       = $clog2(NUM_REGS)
) (
    input  logic                 i_aclk,
    input  logic                 i_areset_n,

    input  logic                 i_valid,
    output logic                 o_stall,

    input  logic [RW-1:0]        i_rdest,
    input  logic                 i_cu_regwrite,
    input  logic [1:0]           i_cu_memtoreg,
    input  logic                 i_cu_memread,
    input  logic                 i_cu_memwrite,
    input  logic [2:0]           i_funct3,
    input  logic [INST_SIZE-1:0] i_pcplus4,
    input  logic [DATA_SIZE-1:0] i_exe_data,
    input  logic [DATA_SIZE-1:0] i_store_data,

    output logic [RW-1:0]        o_rdest,
    output logic                 o_cu_regwrite,
    output logic [1:0]           o_cu_memtoreg,
    output logic [INST_SIZE-1:0] o_pcplus4,
    output logic [DATA_SIZE-1:0] o_exe_data,
    output logic [DATA_SIZE-1:0] o_mem_data,

    output logic                 o_dmem_req,
    output logic                 o_dmem_we,
    output logic [DATA_SIZE-1:0] o_dmem_addr,
    output logic [DATA_SIZE-1:0] o_dmem_wdata,
    output logic [3:0]           o_dmem_be,
    input  logic                 i_dmem_ack,
    input  logic [DATA_SIZE-1:0] i_dmem_rdata,
    output logic                 o_misalign
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    state_t r_state;
    state_t w_state_next;

    logic                 r_valid;
    logic                 r_regwrite;
    logic [RW-1:0]        r_rdest;
    logic [1:0]           r_memtoreg;
    logic                 r_memread;
    logic                 r_memwrite;
    logic [2:0]           r_funct3;
    logic [INST_SIZE-1:0] r_pcplus4;
    logic [DATA_SIZE-1:0] r_exe_data;
    logic [DATA_SIZE-1:0] r_store_data;
    logic [DATA_SIZE-1:0] r_rdata;

    logic                 w_memop;
    logic                 w_misaligned;
    logic                 w_req;
    logic                 w_capture;
    size_t                w_size;
    logic [1:0]           w_offset;
    logic [3:0]           w_be;
    logic [DATA_SIZE-1:0] w_wdata;
    logic [DATA_SIZE-1:0] w_lane;
    logic [DATA_SIZE-1:0] w_load_ext;
    logic                 w_sign;

    // Only the bits that make the stage observable as live need a reset.
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
        end else if (!w_req) begin
            r_valid    <= i_valid;
            r_regwrite <= i_cu_regwrite;
        end
    end

    always_ff @(posedge i_aclk) begin
        if (!w_req) begin
            r_rdest      <= i_rdest;
            r_memtoreg   <= i_cu_memtoreg;
            r_memread    <= i_cu_memread;
            r_memwrite   <= i_cu_memwrite;
            r_funct3     <= i_funct3;
            r_pcplus4    <= i_pcplus4;
            r_exe_data   <= i_exe_data;
            r_store_data <= i_store_data;
        end
    end

    always_ff @(posedge i_aclk) begin
        if (w_capture) begin
            r_rdata <= i_dmem_rdata;
        end
    end

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_size = SZ_WORD;
        case (r_funct3)
            3'b000, 3'b100: w_size = SZ_BYTE;
            3'b001, 3'b101: w_size = SZ_HALF;
            default:        w_size = SZ_WORD;
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    assign w_misaligned = r_valid & (r_memread | r_memwrite) &
                          (((w_size == SZ_HALF) & r_exe_data[0]) |
                           ((w_size == SZ_WORD) & (r_exe_data[1:0] != 2'b00)));
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_memop = r_valid & (r_memread | r_memwrite) & ~w_misaligned;

    // A request is raised combinationally in IDLE so a same-cycle ack needs no WAIT.
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_memop) begin
                    w_req = 1'b1;
                    if (i_dmem_ack) begin
                        w_capture    = 1'b1;
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                w_req = 1'b1;
                if (i_dmem_ack) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_offset = 2'b00;
        w_be     = 4'b1111;
        w_wdata  = r_store_data;
        case (w_size)
            SZ_BYTE: begin
                w_offset = r_exe_data[1:0];
                w_be     = 4'b0001 << w_offset;
                w_wdata  = {(DATA_SIZE/8){r_store_data[7:0]}};
            end
            SZ_HALF: begin
                w_offset = {r_exe_data[1], 1'b0};
                w_be     = 4'b0011 << w_offset;
                w_wdata  = {(DATA_SIZE/16){r_store_data[15:0]}};
            end
            default: begin
                w_offset = 2'b00;
                w_be     = 4'b1111;
                w_wdata  = r_store_data;
            end
        endcase
    end

    // funct3[2] set selects the unsigned load variants.
    always_comb begin
        w_sign     = ~r_funct3[2];
        w_lane     = r_rdata >> {w_offset, 3'b000};
        w_load_ext = w_lane;
        case (w_size)
            SZ_BYTE: w_load_ext = {{(DATA_SIZE-8){w_sign & w_lane[7]}}, w_lane[7:0]};
            SZ_HALF: w_load_ext = {{(DATA_SIZE-16){w_sign & w_lane[15]}}, w_lane[15:0]};
            default: w_load_ext = w_lane;
        endcase
    end

    assign o_stall       = w_req;
    assign o_dmem_req    = w_req;
    assign o_dmem_we     = r_memwrite;
    assign o_dmem_addr   = {r_exe_data[DATA_SIZE-1:2], 2'b00};
    assign o_dmem_wdata  = w_wdata;
    assign o_dmem_be     = w_be;
    assign o_misalign    = w_misaligned;

    assign o_rdest       = r_rdest;
    assign o_cu_memtoreg = r_memtoreg;
    assign o_pcplus4     = r_pcplus4;
    assign o_exe_data    = r_exe_data;

    assign o_cu_regwrite = r_valid & r_regwrite & (~w_memop | (r_state == ST_DONE)) & ~w_misaligned;
    assign o_mem_data    = ((r_state == ST_DONE) && r_valid && r_memread) ? w_load_ext : '0;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed pinned scenarios, then random instruction
// traffic against a cycle-timeline model with a randomly stalling data memory.
`timescale 1ns/1ps

module tb_memory_access;

    localparam int DW = 32;
    localparam int IW = 32;
    localparam int NR = 32;
    localparam int RW = 5;

    logic          clk;
    logic          rstn;
    logic          i_valid;
    logic          o_stall;
    logic [RW-1:0] i_rdest;
    logic          i_cu_regwrite;
    logic [1:0]    i_cu_memtoreg;
    logic          i_cu_memread;
    logic          i_cu_memwrite;
    logic [2:0]    i_funct3;
    logic [IW-1:0] i_pcplus4;
    logic [DW-1:0] i_exe_data;
    logic [DW-1:0] i_store_data;
    logic [RW-1:0] o_rdest;
    logic          o_cu_regwrite;
    logic [1:0]    o_cu_memtoreg;
    logic [IW-1:0] o_pcplus4;
    logic [DW-1:0] o_exe_data;
    logic [DW-1:0] o_mem_data;
    logic          o_dmem_req;
    logic          o_dmem_we;
    logic [DW-1:0] o_dmem_addr;
    logic [DW-1:0] o_dmem_wdata;
    logic [3:0]    o_dmem_be;
    logic          i_dmem_ack;
    logic [DW-1:0] i_dmem_rdata;
    logic          o_misalign;

    memory_access #(.DATA_SIZE(DW), .INST_SIZE(IW), .NUM_REGS(NR)) dut (
        .i_aclk(clk), .i_areset_n(rstn),
        .i_valid(i_valid), .o_stall(o_stall),
        .i_rdest(i_rdest), .i_cu_regwrite(i_cu_regwrite), .i_cu_memtoreg(i_cu_memtoreg),
        .i_cu_memread(i_cu_memread), .i_cu_memwrite(i_cu_memwrite), .i_funct3(i_funct3),
        .i_pcplus4(i_pcplus4), .i_exe_data(i_exe_data), .i_store_data(i_store_data),
        .o_rdest(o_rdest), .o_cu_regwrite(o_cu_regwrite), .o_cu_memtoreg(o_cu_memtoreg),
        .o_pcplus4(o_pcplus4), .o_exe_data(o_exe_data), .o_mem_data(o_mem_data),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be), .i_dmem_ack(i_dmem_ack),
        .i_dmem_rdata(i_dmem_rdata), .o_misalign(o_misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          id;
        logic        valid;
        logic [4:0]  rdest;
        logic        rw;
        logic [1:0]  m2r;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] pc4;
        logic [31:0] exe;
        logic [31:0] sd;
    } instr_t;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:63];

    instr_t      cur;
    instr_t      nxt;
    bit          curLoaded;
    int          k;
    int          dly;
    int          nxtDly;
    int          idCnt;
    int          forceAck;
    bit          randomMode;
    bit          checkEn;
    instr_t      dirQ[$];
    int          dirDlyQ[$];

    bit          expReq, expStall, expRw, expMis, expWe, expMemChk;
    logic [31:0] expMemData, expAddr, expWdata, ackWord;
    logic [3:0]  expBe;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int sizeOf(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic int offsetOf(input instr_t x);
        if (sizeOf(x.f3) == 1) return int'(x.exe % 4);
        if (sizeOf(x.f3) == 2) return int'((x.exe % 4) / 2) * 2;
        return 0;
    endfunction

    function automatic bit isMisaligned(input instr_t x);
`ifdef MEM_MISALIGN_CHECK_EN
        if (sizeOf(x.f3) == 2) return (x.exe % 2) != 0;
        if (sizeOf(x.f3) == 4) return (x.exe % 4) != 0;
        return 0;
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] loadValue(input logic [31:0] word, input instr_t x);
        logic [31:0] s;
        bit          sgn;
        s   = word >> (8 * offsetOf(x));
        sgn = (x.f3 == 3'b000 || x.f3 == 3'b001);
        if (sizeOf(x.f3) == 1) return (sgn && s[7])  ? ((s & 32'hFF)   | 32'hFFFFFF00) : (s & 32'hFF);
        if (sizeOf(x.f3) == 2) return (sgn && s[15]) ? ((s & 32'hFFFF) | 32'hFFFF0000) : (s & 32'hFFFF);
        return word;
    endfunction

    function automatic logic [3:0] storeBe(input instr_t x);
        if (sizeOf(x.f3) == 1) return 4'(1 << offsetOf(x));
        if (sizeOf(x.f3) == 2) return 4'(3 << offsetOf(x));
        return 4'hF;
    endfunction

    function automatic logic [31:0] storeWdata(input instr_t x);
        if (sizeOf(x.f3) == 1) return (x.sd & 32'hFF) * 32'h01010101;
        if (sizeOf(x.f3) == 2) return (x.sd & 32'hFFFF) * 32'h00010001;
        return x.sd;
    endfunction

    function automatic instr_t mk(input logic rd, input logic wr, input logic rw, input logic [1:0] m2r,
                                  input logic [2:0] f3, input logic [31:0] exe, input logic [31:0] sd);
        instr_t x;
        x.id = 0; x.valid = 1'b1; x.rdest = 5'($urandom); x.rw = rw; x.m2r = m2r;
        x.rd = rd; x.wr = wr; x.f3 = f3; x.pc4 = $urandom; x.exe = exe; x.sd = sd;
        return x;
    endfunction

    function automatic instr_t randInstr();
        instr_t x;
        int kind;
        kind = int'($urandom % 8);
        if (kind == 0) begin
            x = mk(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom), $urandom, $urandom);
            x.valid = 1'b0;
        end else if (kind <= 3) begin
            x = mk(1'b0, 1'b0, 1'($urandom), ($urandom % 2) ? 2'b10 : 2'b00, 3'($urandom), $urandom, $urandom);
        end else if (kind <= 5) begin
            x = mk(1'b1, 1'b0, ($urandom % 4) != 0, 2'b01, 3'($urandom), 32'h100 + ($urandom % 256), $urandom);
        end else begin
            x = mk(1'b0, 1'b1, 1'b0, 2'b00, 3'($urandom), 32'h100 + ($urandom % 256), $urandom);
        end
        return x;
    endfunction

    task automatic applyStimulus(input instr_t ins, input int d, output int id);
        ins.id = idCnt++;
        dirQ.push_back(ins);
        dirDlyQ.push_back(d);
        id = ins.id;
    endtask

    task automatic pickNext();
        if (dirQ.size() > 0) begin
            nxt    = dirQ.pop_front();
            nxtDly = dirDlyQ.pop_front();
        end else begin
            nxt    = randomMode ? randInstr() : mk(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
            nxt.valid = randomMode ? nxt.valid : 1'b0;
            nxt.id = idCnt++;
            nxtDly = int'($urandom % 4);
        end
    endtask

    task automatic driveInputs();
        i_valid       = nxt.valid;
        i_rdest       = nxt.rdest;
        i_cu_regwrite = nxt.rw;
        i_cu_memtoreg = nxt.m2r;
        i_cu_memread  = nxt.rd;
        i_cu_memwrite = nxt.wr;
        i_funct3      = nxt.f3;
        i_pcplus4     = nxt.pc4;
        i_exe_data    = nxt.exe;
        i_store_data  = nxt.sd;
    endtask

    // A memory op stalls for dly+1 cycles (ack in the last), then presents results for one cycle.
    task automatic computeCycle();
        bit          v, isMem, mis, memop;
        int          idx;
        logic [3:0]  be;
        logic [31:0] wd;
        v     = curLoaded && cur.valid;
        isMem = v && (cur.rd || cur.wr);
        mis   = isMem && isMisaligned(cur);
        memop = isMem && !mis;
        idx   = int'((cur.exe >> 2) % 64);
        expMis       = mis;
        expMemChk    = 1'b1;
        expMemData   = 32'h0;
        i_dmem_ack   = 1'b0;
        i_dmem_rdata = $urandom;
        if (memop && k <= dly) begin
            be        = storeBe(cur);
            wd        = storeWdata(cur);
            expReq    = 1'b1;
            expStall  = 1'b1;
            expRw     = 1'b0;
            expMemChk = !cur.rd;
            expAddr   = cur.exe & 32'hFFFFFFFC;
            expBe     = be;
            expWdata  = wd;
            expWe     = cur.wr;
            if (k == dly) begin
                i_dmem_ack = 1'b1;
                if (cur.rd) begin
                    i_dmem_rdata = mem[idx];
                    ackWord      = mem[idx];
                end
                if (cur.wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) mem[idx][8*b +: 8] = wd[8*b +: 8];
                    end
                end
            end
        end else begin
            expReq   = 1'b0;
            expStall = 1'b0;
            expRw    = v && cur.rw && !mis;
            if (memop && cur.rd) expMemData = loadValue(ackWord, cur);
            i_dmem_ack = ($urandom % 4) == 0;
            if (forceAck > 0) begin
                i_dmem_ack = 1'b1;
                forceAck--;
            end
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
        if (!rstn) begin
            curLoaded = 1'b0;
            k = 0;
        end else if (!expStall) begin
            cur       = nxt;
            dly       = nxtDly;
            k         = 0;
            curLoaded = 1'b1;
            pickNext();
        end else begin
            k++;
        end
        driveInputs();
        computeCycle();
    endtask

    task automatic waitLoaded(input int id);
        for (int n = 0; n < 64; n++) begin
            stepCycle();
            if (curLoaded && cur.id == id) return;
        end
        checkOutput("load_timeout", 32'h0, 32'h1);
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("dmem_req", o_dmem_req, expReq);
            checkOutput("stall", o_stall, expStall);
            checkOutput("regwrite", o_cu_regwrite, expRw);
            checkOutput("misalign", o_misalign, expMis);
            if (expMemChk) checkOutput("mem_data", o_mem_data, expMemData);
            if (curLoaded) begin
                checkOutput("rdest", o_rdest, cur.rdest);
                checkOutput("memtoreg", o_cu_memtoreg, cur.m2r);
                checkOutput("pcplus4", o_pcplus4, cur.pc4);
                checkOutput("exe_data", o_exe_data, cur.exe);
            end
            if (expReq) begin
                checkOutput("dmem_addr", o_dmem_addr, expAddr);
                checkOutput("dmem_be", o_dmem_be, expBe);
                checkOutput("dmem_we", o_dmem_we, expWe);
                checkOutput("dmem_wdata", o_dmem_wdata, expWdata);
            end
        end
    end

    initial begin
        int id1, id2;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        rstn = 1'b0; curLoaded = 1'b0; k = 0; dly = 0; idCnt = 0; forceAck = 0;
        randomMode = 1'b0; ackWord = 32'h0; expStall = 1'b0; expReq = 1'b0;
        expAddr = 0; expBe = 0; expWdata = 0; expWe = 0;
        pickNext();
        driveInputs();
        computeCycle();
        checkEn = 1'b1;
        repeat (3) stepCycle();
        #3;
        checkOutput("reset_req", o_dmem_req, 32'h0);
        checkOutput("reset_stall", o_stall, 32'h0);
        checkOutput("reset_regwrite", o_cu_regwrite, 32'h0);
        checkOutput("reset_misalign", o_misalign, 32'h0);
        stepCycle();
        rstn = 1'b1;

        $display("[TB] LW 0x100 with same-cycle ack");
        mem[0] = 32'hDEADBEEF;
        applyStimulus(mk(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 32'h100, 32'h0), 0, id1);
        waitLoaded(id1);
        #3;
        checkOutput("lw_req", o_dmem_req, 32'h1);
        checkOutput("lw_addr", o_dmem_addr, 32'h100);
        checkOutput("lw_be", o_dmem_be, 32'hF);
        checkOutput("lw_stall", o_stall, 32'h1);
        stepCycle();
        #3;
        checkOutput("lw_req_done", o_dmem_req, 32'h0);
        checkOutput("lw_stall_done", o_stall, 32'h0);
        checkOutput("lw_data", o_mem_data, 32'hDEADBEEF);
        checkOutput("lw_model", expMemData, 32'hDEADBEEF);
        checkOutput("lw_regwrite", o_cu_regwrite, 32'h1);

        $display("[TB] LB/LBU 0x103 with ack after 3 cycles");
        mem[0] = 32'h80112233;
        for (int s = 0; s < 2; s++) begin
            applyStimulus(mk(1'b1, 1'b0, 1'b1, 2'b01, (s == 0) ? 3'b000 : 3'b100, 32'h103, 32'h0), 3, id1);
            waitLoaded(id1);
            for (int c = 0; c < 4; c++) begin
                #3;
                checkOutput("lb_req_hold", o_dmem_req, 32'h1);
                checkOutput("lb_addr_hold", o_dmem_addr, 32'h100);
                checkOutput("lb_be_hold", o_dmem_be, 32'h8);
                stepCycle();
            end
            #3;
            checkOutput("lb_req_done", o_dmem_req, 32'h0);
            checkOutput("lb_data", o_mem_data, (s == 0) ? 32'hFFFFFF80 : 32'h00000080);
            checkOutput("lb_model", expMemData, (s == 0) ? 32'hFFFFFF80 : 32'h00000080);
        end

        $display("[TB] SH 0x102");
        applyStimulus(mk(1'b0, 1'b1, 1'b0, 2'b00, 3'b001, 32'h102, 32'h0000ABCD), 1, id1);
        waitLoaded(id1);
        #3;
        checkOutput("sh_be", o_dmem_be, 32'hC);
        checkOutput("sh_wdata", o_dmem_wdata, 32'hABCDABCD);
        checkOutput("sh_we", o_dmem_we, 32'h1);
        checkOutput("sh_regwrite", o_cu_regwrite, 32'h0);
        stepCycle();
        stepCycle();
        #3;
        checkOutput("sh_regwrite_done", o_cu_regwrite, 32'h0);
        checkOutput("sh_mem_data", o_mem_data, 32'h0);

        $display("[TB] back-to-back ALU ops");
        applyStimulus(mk(1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 32'h55, 32'h0), 0, id1);
        applyStimulus(mk(1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 32'h66, 32'h0), 0, id2);
        waitLoaded(id1);
        #3;
        checkOutput("add_stall", o_stall, 32'h0);
        checkOutput("add_req", o_dmem_req, 32'h0);
        checkOutput("add_exe", o_exe_data, 32'h55);
        checkOutput("add_regwrite", o_cu_regwrite, 32'h1);
        stepCycle();
        #3;
        checkOutput("add2_exe", o_exe_data, 32'h66);

        $display("[TB] LW 0x101");
        applyStimulus(mk(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 32'h101, 32'h0), 0, id1);
        waitLoaded(id1);
        #3;
`ifdef MEM_MISALIGN_CHECK_EN
        checkOutput("mis_flag", o_misalign, 32'h1);
        checkOutput("mis_req", o_dmem_req, 32'h0);
        checkOutput("mis_regwrite", o_cu_regwrite, 32'h0);
        checkOutput("mis_stall", o_stall, 32'h0);
        stepCycle();
        #3;
        checkOutput("mis_flag_clear", o_misalign, 32'h0);
`else
        checkOutput("unal_req", o_dmem_req, 32'h1);
        checkOutput("unal_addr", o_dmem_addr, 32'h100);
        checkOutput("unal_be", o_dmem_be, 32'hF);
`endif

        $display("[TB] reset during WAIT");
        applyStimulus(mk(1'b1, 1'b0, 1'b1, 2'b01, 3'b000, 32'h104, 32'h0), 6, id1);
        waitLoaded(id1);
        stepCycle();
        #2;
        rstn = 1'b0;
        curLoaded = 1'b0;
        dirQ.delete();
        dirDlyQ.delete();
        nxt = mk(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
        nxt.valid = 1'b0;
        nxt.id = idCnt++;
        driveInputs();
        computeCycle();
        #1;
        checkOutput("rst_req_drop", o_dmem_req, 32'h0);
        checkOutput("rst_stall_drop", o_stall, 32'h0);
        stepCycle();
        stepCycle();
        forceAck = 3;
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            stepCycle();
            #3;
            checkOutput("late_ack_regwrite", o_cu_regwrite, 32'h0);
            checkOutput("late_ack_req", o_dmem_req, 32'h0);
        end

        $display("[TB] random traffic");
        randomMode = 1'b1;
        repeat (4000) stepCycle();
        randomMode = 1'b0;
        repeat (20) stepCycle();
        #3;
        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL take parameters from multicore_pkg: DATA_SIZE, default 32, data/address width; INST_SIZE, default 32, PC width; NUM_REGS, default 32, register count (RW = $clog2(NUM_REGS)).
REQ-002 i_aclk  in  1  clock (rising edge).
REQ-003 i_areset_n  in  1  reset, asynchronous, active-low.
REQ-004 i_valid  in  1  instruction from execute valid; o_stall  out  1  upstream SHALL hold all inputs while high.
REQ-005 i_rdest/o_rdest  in/out  RW  destination register; i_cu_regwrite/o_cu_regwrite  in/out  1; i_cu_memtoreg/o_cu_memtoreg  in/out  2  (00 ALU, 01 mem, 10 PC+4).
REQ-006 i_cu_memread  in  1  load; i_cu_memwrite  in  1  store; i_funct3  in  3  access size/sign.
REQ-007 i_pcplus4/o_pcplus4  in/out  INST_SIZE; i_exe_data/o_exe_data  in/out  DATA_SIZE  ALU result/effective address; i_store_data  in  DATA_SIZE; o_mem_data  out  DATA_SIZE  extended load result.
REQ-008 o_dmem_req  out  1; o_dmem_we  out  1; o_dmem_addr  out  DATA_SIZE; o_dmem_wdata  out  DATA_SIZE; o_dmem_be  out  4; i_dmem_ack  in  1; i_dmem_rdata  in  DATA_SIZE; o_misalign  out  1.

Function
REQ-009 Stage registers (r_*) SHALL load all inputs on a clock edge where o_stall=0 and hold otherwise.
REQ-010 FSM states IDLE, WAIT, DONE; memop = r_valid & (r_memread | r_memwrite) & ~misaligned.
REQ-011 IDLE: memop -> o_dmem_req=1, o_stall=1; i_dmem_ack same cycle -> latch rdata, go DONE; else go WAIT. No memop -> stay IDLE, o_stall=0.
REQ-012 WAIT: o_dmem_req, addr, we, wdata, be SHALL stay stable; o_stall=1; on i_dmem_ack latch rdata, go DONE.
REQ-013 DONE: o_dmem_req=0, o_stall=0, results presented; next edge -> IDLE and stage reloads.
REQ-014 Latency: non-memory op 1 cycle; memory op minimum 2 cycles (IDLE ack + DONE).
REQ-015 o_cu_regwrite = r_valid & r_regwrite & (no memop | state==DONE) & ~misaligned; 0 (bubble) in every stalled cycle.
REQ-016 o_rdest, o_cu_memtoreg, o_pcplus4, o_exe_data SHALL be driven directly from r_*.
REQ-017 o_dmem_addr = {r_exe_data[DATA_SIZE-1:2], 2'b00}; o_dmem_we = r_memwrite.
REQ-018 funct3 000/100 byte: be = 0001<<addr[1:0], wdata = byte replicated x4; 001/101 half: be = 0011<<{addr[1],0}, wdata = half replicated x2; other codes word: be=1111.
REQ-019 Loads: lane selected by addr[1:0]; 000/001 sign-extend, 100/101 zero-extend, word unchanged; o_mem_data=0 for stores and non-memory ops.
REQ-020 Simultaneous i_dmem_ack in DONE/IDLE without request SHALL be ignored.

Reset
REQ-021 While i_areset_n=0: state IDLE, r_valid=0, r_regwrite=0, o_dmem_req=0, o_stall=0, o_cu_regwrite=0, o_misalign=0; other r_* unreset.
REQ-022 Reset asserted in WAIT SHALL drop o_dmem_req immediately and abandon the access; a late ack after reset is ignored.

Configuration
REQ-023 Macro MEM_MISALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> no request, o_misalign=1 for that single stage cycle, o_cu_regwrite=0, o_stall=0.
REQ-024 Macro undefined: o_misalign tied 0, misaligned=0, low address bits ignored for lane selection beyond the access size (half uses addr[1], word none).

Verification
REQ-025 LW addr 0x100, ack same cycle, rdata 0xDEADBEEF -> req 1 cycle, be=1111, o_mem_data=0xDEADBEEF, o_cu_regwrite=1 next cycle, stall 1 cycle.
REQ-026 LB addr 0x103, rdata 0x80112233, ack after 3 cycles -> req held 4 cycles stable, o_mem_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-027 SH addr 0x102, store 0x0000ABCD -> be=1100, wdata=0xABCDABCD, we=1, o_cu_regwrite=0.
REQ-028 ADD result 0x55, i_valid=1 back-to-back -> o_stall=0, o_exe_data=0x55 next cycle, no o_dmem_req.
REQ-029 Reset asserted in WAIT -> o_dmem_req=0 asynchronously, state IDLE, later ack produces no regwrite.
REQ-030 With MEM_MISALIGN_CHECK_EN, LW addr 0x101 -> o_misalign=1 one cycle, no req, regwrite 0; without macro -> req with addr 0x100, be=1111.
